fir_mac_scheduler: RTL

FIR_MAC_SCHEDULER -- requirements
Module: fir_mac_scheduler

---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_sample_ring.sv | 59 +++++
 rtl/fir_mac_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR MAC scheduler.
// Contents: FSM state enum, default coefficient value, default N/TAPS/CW.
// Imported by fir_sample_ring and fir_mac_scheduler.
package fir_pkg;

    localparam int N_DEF    = 32;
    localparam int TAPS_DEF = 4;
    localparam int CW_DEF   = 8;

    // 0x20 on every tap of a 4-tap filter gives a scaled moving average.
    localparam int COEF_DEF = 'h20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_e;

endpackage

// File: rtl/fir_sample_ring.sv
// Circular sample buffer: one write port, one registered read relative to the newest sample.
// Ports: wr_en/wr_dat write at wr_ptr; rd_off selects x[n-rd_off], result on rd_dat one cycle later.
// Latency: read data registered (1 cycle); warm flags TAPS samples written since reset.
module fir_sample_ring #(
    parameter int N    = 32,
    parameter int TAPS = 4,
    parameter int AW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [N-1:0]  wr_dat,
    input  logic [AW-1:0] rd_off,
    output logic [N-1:0]  rd_dat,
    output logic          warm
);

    localparam logic [AW-1:0] PTR_LAST  = AW'(TAPS - 1);
    localparam logic [AW:0]   FILL_FULL = (AW + 1)'(TAPS);

    logic [N-1:0]  r_ring [TAPS];
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_fill;
    logic [N-1:0]  r_rd_dat;

    logic [AW-1:0] w_newest;
    logic [AW-1:0] w_rd_idx;

    // Newest sample sits one behind the write pointer.
    assign w_newest = (r_wr_ptr == '0) ? PTR_LAST : r_wr_ptr - 1'b1;

    // (newest - off) mod TAPS; the add of TAPS keeps non-power-of-two depths correct.
    assign w_rd_idx = (w_newest >= rd_off) ? (w_newest - rd_off)
                                           : (w_newest + AW'(TAPS) - rd_off);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_ring[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_rd_dat <= '0;
        end else begin
            r_rd_dat <= r_ring[w_rd_idx];
            if (wr_en) begin
                r_ring[r_wr_ptr] <= wr_dat;
                r_wr_ptr         <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
                if (r_fill != FILL_FULL) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end
    end

    assign rd_dat = r_rd_dat;
    assign warm   = (r_fill == FILL_FULL);

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR filter: one multiply-accumulate per cycle over TAPS taps per sample.
// Ports: coef_* write port with coef_err, in_* / out_* valid-ready sample/result streams, out_warm, busy.
// Latency: sample accepted at edge t -> out_valid from edge t+TAPS+1; in_ready low while busy, result held until out_ready.
module fir_mac_scheduler
    import fir_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int TAPS = TAPS_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     coef_wr,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [CW-1:0]            coef_data,
    output logic                     coef_err,
    input  logic                     in_valid,
    input  logic [N-1:0]             in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [N-1:0]             out_data,
    input  logic                     out_ready,
    output logic                     out_warm,
    output logic                     busy
);

    localparam int            AW     = $clog2(TAPS);
    localparam logic [AW:0]   K_LAST = (AW + 1)'(TAPS);

    fir_state_e    r_state;
    fir_state_e    w_state_nxt;
    logic [N-1:0]  r_acc;
    logic [AW:0]   r_k;
    logic [AW-1:0] r_tap;
    logic [CW-1:0] r_coef [TAPS];
    logic          r_coef_err;

    logic          w_accept;
    logic          w_coef_ok;
    logic [AW-1:0] w_rd_off;
    logic [N-1:0]  w_ring_dat;
    logic [N-1:0]  w_prod;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_coef_ok = coef_wr && (r_state == IDLE) && ({1'b0, coef_addr} < K_LAST);

    // The ring read is registered, so MAC spends k=0 issuing the first read and
    // k=1..TAPS accumulating; r_tap remembers which tap the read data belongs to.
    assign w_rd_off = (r_k < K_LAST) ? r_k[AW-1:0] : '0;
    assign w_prod   = w_ring_dat * N'(r_coef[r_tap]);

    fir_sample_ring #(
        .N    (N),
        .TAPS (TAPS),
        .AW   (AW)
    ) u_ring (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (w_accept),
        .wr_dat (in_data),
        .rd_off (w_rd_off),
        .rd_dat (w_ring_dat),
        .warm   (out_warm)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_accept) begin
                    w_state_nxt = MAC;
                end
            end
            MAC: begin
                if (r_k == K_LAST) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                out_data  = r_acc;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_k   <= '0;
            r_tap <= '0;
        end else begin
            r_tap <= w_rd_off;
            if (w_accept) begin
                r_acc <= '0;
                r_k   <= '0;
            end else if (r_state == MAC) begin
                if (r_k != '0) begin
                    r_acc <= r_acc + w_prod;
                end
                if (r_k != K_LAST) begin
                    r_k <= r_k + 1'b1;
                end
            end
        end
    end

    // A write in the same cycle as an accepted sample lands before the first
    // MAC cycle, so the new coefficient already applies to that sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_coef[i] <= CW'(COEF_DEF);
            end
            r_coef_err <= 1'b0;
        end else begin
            if (w_coef_ok) begin
                r_coef[coef_addr] <= coef_data;
            end
            r_coef_err <= coef_wr && !w_coef_ok;
        end
    end

    assign coef_err = r_coef_err;

endmodule
